// File: rtl/output_dma_scheduler.sv
// Output DMA scheduler: drains the output buffer into the AXI DMA S2MM channel,
// one length command per batch, and pulses next_batch once both the buffer read
// side and the DMA have finished that batch. A watchdog flags stalled transfers.
module output_dma_scheduler #(
    parameter int NUM_BATCH  = 8,
    parameter int BEAT_BYTES = 8,
    parameter int LEN_WIDTH  = 23,
    parameter int TMO_WIDTH  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           layer,
    input  logic                 is_dma_send,
    input  logic                 onebatch_done,
    input  logic                 onetranstime_done,
    input  logic                 read_done,
    input  logic                 dma_done,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output logic [LEN_WIDTH-1:0] cmd_len,
    output logic                 next_batch,
    output logic                 busy,
    output logic                 layer_done,
    output logic [2:0]           batch_idx,
    output logic [15:0]          trans_cnt,
    output logic                 err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CMD,
        S_XFER,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [TMO_WIDTH-1:0] WD_MAX     = '1;
    localparam logic [TMO_WIDTH-1:0] WD_ONE     = TMO_WIDTH'(1);
    // Expiry fires on the edge that closes the (2**TMO_WIDTH-1)th cycle in a state.
    localparam logic [TMO_WIDTH-1:0] WD_LIMIT   = WD_MAX - WD_ONE;
    localparam logic [2:0]           LAST_BATCH = 3'(NUM_BATCH - 1);

    state_t               state;
    logic [2:0]           layer_q;
    logic                 send_flag;
    logic                 rd_flag;
    logic                 dma_flag;
    logic                 read_done_flag;
    logic [TMO_WIDTH-1:0] wd;

    logic wd_expire;
    logic rd_hit;
    logic dma_hit;

    // Byte length of one batch: beats halve per layer down to a floor of 128.
    function automatic logic [LEN_WIDTH-1:0] batch_len(input logic [2:0] l);
        int unsigned beats;
        case (l)
            3'd0:    beats = 4096;
            3'd1:    beats = 2048;
            3'd2:    beats = 1024;
            3'd3:    beats = 512;
            3'd4:    beats = 256;
            default: beats = 128;
        endcase
        return LEN_WIDTH'(beats * BEAT_BYTES);
    endfunction

    // Completion and expiry qualifiers, counting pulses arriving this very cycle.
    always_comb begin
        wd_expire = (wd == WD_LIMIT);
        rd_hit    = rd_flag | onebatch_done;
        dma_hit   = dma_flag | dma_done;
    end

    // Sequencer FSM with registered outputs, watchdog and per-layer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            layer_q        <= '0;
            send_flag      <= 1'b0;
            rd_flag        <= 1'b0;
            dma_flag       <= 1'b0;
            read_done_flag <= 1'b0;
            wd             <= '0;
            cmd_valid      <= 1'b0;
            cmd_len        <= '0;
            next_batch     <= 1'b0;
            busy           <= 1'b0;
            layer_done     <= 1'b0;
            batch_idx      <= '0;
            trans_cnt      <= '0;
            err_timeout    <= 1'b0;
        end else begin
            next_batch <= 1'b0;
            layer_done <= 1'b0;

            if (busy && onetranstime_done)
                trans_cnt <= trans_cnt + 16'd1;
            if (busy && read_done)
                read_done_flag <= 1'b1;

            // Watchdog advances only in the states that wait on outside parties;
            // every state transition below overrides it back to zero.
            if ((state == S_WAIT) || (state == S_CMD) || (state == S_XFER))
                wd <= (wd == WD_MAX) ? wd : wd + WD_ONE;

            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state          <= S_WAIT;
                        layer_q        <= layer;
                        batch_idx      <= '0;
                        trans_cnt      <= '0;
                        err_timeout    <= 1'b0;
                        busy           <= 1'b1;
                        // The buffer may raise is_dma_send together with start.
                        send_flag      <= is_dma_send;
                        rd_flag        <= 1'b0;
                        dma_flag       <= 1'b0;
                        read_done_flag <= 1'b0;
                        wd             <= '0;
                    end
                end
                S_WAIT: begin
                    if (is_dma_send || send_flag) begin
                        state     <= S_CMD;
                        cmd_valid <= 1'b1;
                        cmd_len   <= batch_len(layer_q);
                        send_flag <= 1'b0;
                        wd        <= '0;
                    end else if (wd_expire) begin
                        state       <= S_ERR;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        wd          <= '0;
                    end
                end
                S_CMD: begin
                    if (onebatch_done)
                        rd_flag <= 1'b1;
                    if (dma_done)
                        dma_flag <= 1'b1;
                    if (cmd_ready) begin
                        state     <= S_XFER;
                        cmd_valid <= 1'b0;
                        wd        <= '0;
                    end else if (wd_expire) begin
                        state       <= S_ERR;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cmd_valid   <= 1'b0;
                        wd          <= '0;
                    end
                end
                S_XFER: begin
                    if (rd_hit && dma_hit) begin
                        state      <= S_NEXT;
                        next_batch <= 1'b1;
                        rd_flag    <= 1'b0;
                        dma_flag   <= 1'b0;
                        wd         <= '0;
                    end else begin
                        if (onebatch_done)
                            rd_flag <= 1'b1;
                        if (dma_done)
                            dma_flag <= 1'b1;
                        if (wd_expire) begin
                            state       <= S_ERR;
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            wd          <= '0;
                        end
                    end
                end
                S_NEXT: begin
                    if ((batch_idx == LAST_BATCH) || read_done_flag || read_done) begin
                        state      <= S_DONE;
                        layer_done <= 1'b1;
                    end else begin
                        state     <= S_CMD;
                        batch_idx <= batch_idx + 3'd1;
                        cmd_valid <= 1'b1;
                        cmd_len   <= batch_len(layer_q);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_dma_scheduler.sv
// Bench for output_dma_scheduler: directed layer runs plus randomized runs,
// each checked against expectations derived from layer, batch and pulse counts.
module tb_output_dma_scheduler;

    localparam int TMO_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  layer;
    logic        is_dma_send;
    logic        onebatch_done;
    logic        onetranstime_done;
    logic        read_done;
    logic        dma_done;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [22:0] cmd_len;
    logic        next_batch;
    logic        busy;
    logic        layer_done;
    logic [2:0]  batch_idx;
    logic [15:0] trans_cnt;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int nb_cnt   = 0;
    int ld_cnt   = 0;

    output_dma_scheduler #(
        .NUM_BATCH (8),
        .BEAT_BYTES(8),
        .LEN_WIDTH (23),
        .TMO_WIDTH (TMO_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .layer            (layer),
        .is_dma_send      (is_dma_send),
        .onebatch_done    (onebatch_done),
        .onetranstime_done(onetranstime_done),
        .read_done        (read_done),
        .dma_done         (dma_done),
        .cmd_ready        (cmd_ready),
        .cmd_valid        (cmd_valid),
        .cmd_len          (cmd_len),
        .next_batch       (next_batch),
        .busy             (busy),
        .layer_done       (layer_done),
        .batch_idx        (batch_idx),
        .trans_cnt        (trans_cnt),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    // Event counters: handshakes, next_batch cycles and layer_done cycles.
    always @(posedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;
            if (next_batch)             nb_cnt <= nb_cnt + 1;
            if (layer_done)             ld_cnt <= ld_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 4096 beats at layer 0, halving each layer, never below 128.
    function automatic int exp_len(input int l);
        int beats;
        beats = 4096 >> l;
        if (beats < 128) beats = 128;
        return beats * 8;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_len"}, cmd_len, 0);
        check({tag, "_next_batch"}, next_batch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_layer_done"}, layer_done, 0);
        check({tag, "_batch_idx"}, batch_idx, 0);
        check({tag, "_trans_cnt"}, trans_cnt, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic wait_cmd(input string tag);
        int w;
        w = 0;
        while (!cmd_valid && w < 40) begin
            tick();
            w++;
        end
        check(tag, cmd_valid, 1);
    endtask

    // One layer: order 0 = onebatch then dma (random gap), 1 = dma 10 cycles
    // before onebatch, 2 = both same cycle. rd_b = batch carrying read_done,
    // abort_b = batch whose XFER is hit by rst.
    task automatic run_layer(input int lay, input int rdy_dly, input int order,
                             input int rd_b, input int send_dly, input int abort_b);
        int          ncmd, hs0, nb0, ld0, tc, k, gap;
        logic [22:0] len0;
        bit          stable;
        ncmd = (rd_b >= 0) ? rd_b + 1 : 8;
        hs0 = hs_cnt; nb0 = nb_cnt; ld0 = ld_cnt; tc = 0;
        layer = lay[2:0];
        start = 1'b1;
        if (send_dly == 0) is_dma_send = 1'b1;
        tick();
        start = 1'b0; is_dma_send = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_after_start", err_timeout, 0);
        if (send_dly > 0) begin
            repeat (send_dly - 1) tick();
            check("no_cmd_before_send", cmd_valid, 0);
            is_dma_send = 1'b1;
            tick();
            is_dma_send = 1'b0;
            check("cmd_latency", cmd_valid, 1);
        end
        for (int b = 0; b < ncmd; b++) begin
            wait_cmd("cmd_valid_wait");
            check("batch_idx", batch_idx, b);
            check("cmd_len", cmd_len, exp_len(lay));
            len0 = cmd_len; stable = 1'b1;
            repeat (rdy_dly) begin
                tick();
                if (!cmd_valid || cmd_len !== len0) stable = 1'b0;
            end
            if (rdy_dly > 0) check("cmd_stable", stable, 1);
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check("cmd_drop", cmd_valid, 0);
            if (b == abort_b) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_all_zero("abort");
                return;
            end
            k = $urandom_range(0, 3);
            repeat (k) begin
                onetranstime_done = 1'b1; tick(); onetranstime_done = 1'b0; tc++;
            end
            if (b == rd_b) begin
                read_done = 1'b1; tick(); read_done = 1'b0;
            end
            if (order == 0) begin
                gap = $urandom_range(0, 5);
                onebatch_done = 1'b1; tick(); onebatch_done = 1'b0;
                repeat (gap) tick();
                check("nb_early", next_batch, 0);
                dma_done = 1'b1; tick(); dma_done = 1'b0;
            end else if (order == 1) begin
                dma_done = 1'b1; tick(); dma_done = 1'b0;
                repeat (9) tick();
                check("nb_early", next_batch, 0);
                onebatch_done = 1'b1; tick(); onebatch_done = 1'b0;
            end else begin
                onebatch_done = 1'b1; dma_done = 1'b1; tick();
                onebatch_done = 1'b0; dma_done = 1'b0;
            end
            check("next_batch", next_batch, 1);
            tick();
            if (b == ncmd - 1) begin
                check("layer_done", layer_done, 1);
                tick();
                check("busy_end", busy, 0);
                check("layer_done_drop", layer_done, 0);
            end
        end
        tick();
        check("hs_count", hs_cnt - hs0, ncmd);
        check("nb_count", nb_cnt - nb0, ncmd);
        check("ld_count", ld_cnt - ld0, 1);
        check("final_batch_idx", batch_idx, ncmd - 1);
        check("trans_cnt", trans_cnt, tc);
        check("idle_cmd_valid", cmd_valid, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; layer = '0; is_dma_send = 1'b0;
        onebatch_done = 1'b0; onetranstime_done = 1'b0; read_done = 1'b0;
        dma_done = 1'b0; cmd_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_layer(0, 0, 0, -1, 5, -1);
        run_layer(6, 0, 1, -1, 2, -1);
        run_layer(3, 20, 2, -1, 0, -1);
        run_layer(4, 1, 0, 3, 1, -1);

        // Stalled transfer: dma_done never arrives.
        layer = 3'd2; start = 1'b1; is_dma_send = 1'b1;
        tick();
        start = 1'b0; is_dma_send = 1'b0;
        wait_cmd("tmo_cmd_wait");
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        onebatch_done = 1'b1; tick(); onebatch_done = 1'b0;
        n = 1;
        while (!err_timeout && n < 200) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 63);
        check("tmo_err", err_timeout, 1);
        check("tmo_busy", busy, 0);
        check("tmo_cmd_valid", cmd_valid, 0);
        run_layer(5, 2, 2, -1, 3, -1);

        run_layer(1, 3, 0, -1, 1, 2);
        run_layer(1, 2, 0, -1, 1, -1);

        for (int i = 0; i < 4; i++) begin
            int rb;
            rb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            run_layer($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 2),
                      rb, $urandom_range(0, 8), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
